edge_event_arbiter: RTL and testbench

- Multi-channel edge-event scheduler.
- Each channel has a toggle (XOR) edge detector; every edge queues one event in that channel's pending counter.
- A round-robin arbiter shares one downstream event port between the channels, using a valid/ready handshake.
- Sits between a set of synchronous status lines and a single event consumer. The consumer sees one event per detected edge, tagged with the channel index.

---
 rtl/edge_event_arbiter.sv | 122 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel toggle detectors feed saturating
// pending counters, drained one event at a time through a round-robin valid/ready port.
module edge_event_arbiter #(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 3,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            pend_any,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  logic [N_CH-1:0]  in_d;
  logic [CNT_W-1:0] pend_cnt [N_CH];
  logic [CH_W-1:0]  last_grant;

  logic [N_CH-1:0]  edge_det;
  logic [N_CH-1:0]  nonzero;
  logic [N_CH-1:0]  dec_vec;
  logic [N_CH-1:0]  ovf_set;
  logic             load;
  logic             found;
  logic [CH_W-1:0]  cand;
  logic [CH_W-1:0]  sel;

  assign edge_det = (in ^ in_d) & en;

  always_comb begin
    nonzero = '0;
    for (int i = 0; i < N_CH; i++) begin
      nonzero[i] = (pend_cnt[i] != '0);
    end
  end

  assign pend_any = |nonzero;
  assign load     = (!evt_valid || evt_ready) && pend_any;

  // Rotating priority: the search starts just after the last granted channel.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(last_grant) + k) % N_CH);
      if (!found && nonzero[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    dec_vec = '0;
    ovf_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      dec_vec[i] = load && (sel == CH_W'(i));
      ovf_set[i] = edge_det[i] && !dec_vec[i] && (pend_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_d <= '0;
    end else begin
      in_d <= in;
    end
  end

  // A simultaneous edge and grant cancel, so a full counter never overflows then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        pend_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case ({edge_det[i], dec_vec[i]})
          2'b10: begin
            if (pend_cnt[i] != CNT_MAX) begin
              pend_cnt[i] <= pend_cnt[i] + CNT_W'(1);
            end
          end
          2'b01:   pend_cnt[i] <= pend_cnt[i] - CNT_W'(1);
          default: pend_cnt[i] <= pend_cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= '0;
    end else begin
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      last_grant <= LAST_CH;
    end else if (load) begin
      evt_valid  <= 1'b1;
      evt_ch     <= sel;
      last_grant <= sel;
    end else if (evt_ready) begin
      evt_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_edge_event_arbiter;

  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int CH_W  = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    in_s = '0;
  logic [N-1:0]    en_s = '1;
  logic            evt_ready = 1'b1;
  logic [N-1:0]    ovf_clr_s = '0;
  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            pend_any;
  logic [N-1:0]    ovf;

  int checks = 0;
  int errors = 0;

  edge_event_arbiter #(.N_CH(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .en        (en_s),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .pend_any  (pend_any),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr_s)
  );

  always #5 clk = ~clk;

  // Behavioural reference: integer counts and a rotating search by modulo.
  int        m_cnt [N];
  bit        m_valid;
  int        m_ch;
  int        m_last;
  bit [N-1:0] m_ovf;
  bit [N-1:0] m_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
      m_valid <= 1'b0;
      m_ch    <= 0;
      m_last  <= N - 1;
      m_ovf   <= '0;
      m_prev  <= '0;
    end else begin : step
      automatic bit [N-1:0] edges;
      automatic int total = 0;
      automatic int sel = -1;
      automatic bit load;
      automatic bit [N-1:0] setv = '0;
      edges = (in_s ^ m_prev) & en_s;
      for (int i = 0; i < N; i++) total += m_cnt[i];
      load = (!m_valid || evt_ready) && (total > 0);
      if (load) begin
        for (int k = 1; k <= N; k++) begin
          if (sel < 0 && m_cnt[(m_last + k) % N] > 0) sel = (m_last + k) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (edges[i] && sel != i) begin
          if (m_cnt[i] < CMAX) m_cnt[i] <= m_cnt[i] + 1;
          else setv[i] = 1'b1;
        end else if (!edges[i] && sel == i) begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
      m_ovf <= setv | (m_ovf & ~ovf_clr_s);
      if (load) begin
        m_valid <= 1'b1;
        m_ch    <= sel;
        m_last  <= sel;
      end else if (m_valid && evt_ready) begin
        m_valid <= 1'b0;
      end
      m_prev <= in_s;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    automatic int total = 0;
    for (int i = 0; i < N; i++) begin
      total += m_cnt[i];
      checkOutput($sformatf("model pend_cnt[%0d]", i), int'(dut.pend_cnt[i]), m_cnt[i]);
    end
    checkOutput("model evt_valid", int'(evt_valid), int'(m_valid));
    checkOutput("model evt_ch", int'(evt_ch), m_ch);
    checkOutput("model pend_any", int'(pend_any), int'(total > 0));
    checkOutput("model ovf", int'(ovf), int'(m_ovf));
  end

  task automatic applyStimulus(input logic [N-1:0] toggle, input logic [N-1:0] en_v,
                               input logic rdy, input logic [N-1:0] clr);
    @(negedge clk);
    in_s      = in_s ^ toggle;
    en_s      = en_v;
    evt_ready = rdy;
    ovf_clr_s = clr;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst       = 1'b1;
    in_s      = '0;
    en_s      = '1;
    evt_ready = 1'b1;
    ovf_clr_s = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int accepted;
    int bias;
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset evt_valid", int'(evt_valid), 0);
    checkOutput("reset evt_ch", int'(evt_ch), 0);
    checkOutput("reset pend_any", int'(pend_any), 0);
    checkOutput("reset ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single edge on channel 2
    applyStimulus(4'b0100, 4'hF, 1'b1, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("single cnt2", int'(dut.pend_cnt[2]), 1);
    checkOutput("single valid early", int'(evt_valid), 0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("single valid", int'(evt_valid), 1);
    checkOutput("single ch", int'(evt_ch), 2);
    checkOutput("single pend_any", int'(pend_any), 0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("single valid drop", int'(evt_valid), 0);

    // Round-robin order
    applyReset();
    applyStimulus(4'b1011, 4'hF, 1'b1, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("rr first", int'(evt_ch), 0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("rr second", int'(evt_ch), 1);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("rr third", int'(evt_ch), 3);
    checkOutput("rr third valid", int'(evt_valid), 1);
    applyStimulus(4'b1001, 4'hF, 1'b1, 4'h0);
    checkOutput("rr idle", int'(evt_valid), 0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("rr wrap first", int'(evt_ch), 0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("rr wrap second", int'(evt_ch), 3);

    // Backpressure on channel 1
    applyReset();
    repeat (3) applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    checkOutput("bp valid", int'(evt_valid), 1);
    checkOutput("bp ch", int'(evt_ch), 1);
    checkOutput("bp cnt1", int'(dut.pend_cnt[1]), 2);
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
      if (evt_valid && evt_ready) begin
        accepted++;
        checkOutput("bp accepted ch", int'(evt_ch), 1);
      end
    end
    checkOutput("bp accepted count", accepted, 3);

    // Saturation and sticky overflow on channel 0
    applyReset();
    repeat (9) applyStimulus(4'b0001, 4'hF, 1'b0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    checkOutput("ovf cnt0", int'(dut.pend_cnt[0]), 7);
    checkOutput("ovf set", int'(ovf), 1);
    checkOutput("ovf loaded ch", int'(evt_ch), 0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0001);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    checkOutput("ovf cleared", int'(ovf), 0);
    applyStimulus(4'b0001, 4'hF, 1'b0, 4'b0001);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    checkOutput("ovf set beats clr", int'(ovf), 1);
    checkOutput("ovf cnt0 held", int'(dut.pend_cnt[0]), 7);

    // Edge and grant in the same cycle on a full channel 2
    applyReset();
    applyStimulus(4'b0001, 4'hF, 1'b0, 4'h0);
    repeat (7) applyStimulus(4'b0100, 4'hF, 1'b0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    checkOutput("incdec cnt2 full", int'(dut.pend_cnt[2]), 7);
    applyStimulus(4'b0100, 4'hF, 1'b1, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    checkOutput("incdec cnt2", int'(dut.pend_cnt[2]), 7);
    checkOutput("incdec ovf", int'(ovf), 0);
    checkOutput("incdec ch", int'(evt_ch), 2);

    // Masked channel 3, then re-enable without a line change
    applyReset();
    applyStimulus(4'b1000, 4'b0111, 1'b1, 4'h0);
    repeat (3) applyStimulus(4'b0000, 4'b0111, 1'b1, 4'h0);
    checkOutput("en masked valid", int'(evt_valid), 0);
    checkOutput("en masked pend", int'(pend_any), 0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    repeat (2) applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("en reenable valid", int'(evt_valid), 0);

    // Asynchronous reset while an event is offered
    applyReset();
    applyStimulus(4'b0010, 4'hF, 1'b0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'h0);
    checkOutput("rst pre valid", int'(evt_valid), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst async valid", int'(evt_valid), 0);
    checkOutput("rst async ch", int'(evt_ch), 0);
    checkOutput("rst async pend", int'(pend_any), 0);
    in_s = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("rst no replay", int'(evt_valid), 0);

    // Randomized traffic, phases of varying consumer readiness
    bias = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) bias = $urandom_range(0, 4);
      applyStimulus(N'($urandom) & N'($urandom),
                    ($urandom_range(0, 7) == 0) ? N'($urandom) : {N{1'b1}},
                    ($urandom_range(0, 3) < bias),
                    ($urandom_range(0, 15) == 0) ? N'($urandom) : '0);
    end
    repeat (40) applyStimulus(4'b0000, 4'hF, 1'b1, 4'h0);
    checkOutput("drain pend_any", int'(pend_any), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
